// File: rtl/dcache_pkg.sv
// dcache_pkg: shared encodings, address slicing and MSHR entry layout for the data cache controller
package dcache_pkg;
  localparam int IDX_W = 7;
  localparam int TAG_W = 22;
  localparam int IDX_LSB = 3;
  localparam int TAG_LSB = 10;
  localparam int MTAG_W = 4;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_LOAD = 2'd1, CMD_STORE = 2'd2} mem_cmd_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic valid;
    logic nofill;
    logic [MTAG_W-1:0] mtag;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } mshr_entry_t;
  function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction
  function automatic logic [TAG_W-1:0] addr_tag(input logic [63:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction
endpackage

// File: rtl/dcache_mshr.sv
// dcache_mshr: outstanding load-miss file with lowest-free allocation, memory-tag CAM and index CAM
module dcache_mshr
  import dcache_pkg::*;
#(
  parameter int N = 4,
  parameter int ID_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic [MTAG_W-1:0] alloc_mtag,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [ID_W-1:0]   alloc_id,
  input  logic [MTAG_W-1:0] fill_mtag,
  output logic              fill_hit,
  output logic              fill_nofill,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [ID_W-1:0]   fill_id,
  input  logic              mark,
  input  logic [IDX_W-1:0]  mark_idx,
  input  logic [MTAG_W-1:0] probe_mtag,
  output logic              probe_dup,
  output logic              full,
  output logic              empty
);
  localparam int SEL_W = $clog2(N);
  mshr_entry_t ent [N];
  logic [ID_W-1:0] ids [N];
  logic [N-1:0] hit_vec;
  logic [SEL_W-1:0] free_sel, hit_sel;
  always_comb begin
    free_sel = '0;
    hit_sel = '0;
    hit_vec = '0;
    full = 1'b1;
    empty = 1'b1;
    probe_dup = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      hit_vec[i] = ent[i].valid && fill_mtag != '0 && ent[i].mtag == fill_mtag;
      if (!ent[i].valid) begin
        free_sel = SEL_W'(i);
        full = 1'b0;
      end
      if (hit_vec[i]) hit_sel = SEL_W'(i);
      if (ent[i].valid) empty = 1'b0;
      if (ent[i].valid && ent[i].mtag == probe_mtag) probe_dup = 1'b1;
    end
    fill_hit = |hit_vec;
    fill_nofill = ent[hit_sel].nofill;
    fill_idx = ent[hit_sel].idx;
    fill_tag = ent[hit_sel].tag;
    fill_id = ids[hit_sel];
  end
  // a store to a line with a pending fill marks it so the older fill data is not written
  always_ff @(posedge clock)
    if (reset)
      for (int i = 0; i < N; i++) ent[i].valid <= 1'b0;
    else
      for (int i = 0; i < N; i++) begin
        if (hit_vec[i]) ent[i].valid <= 1'b0;
        else if (mark && ent[i].valid && ent[i].idx == mark_idx) ent[i].nofill <= 1'b1;
        if (alloc && !full && i == int'(free_sel)) begin
          ent[i] <= '{valid: 1'b1, nofill: 1'b0, mtag: alloc_mtag, idx: alloc_idx, tag: alloc_tag};
          ids[i] <= alloc_id;
        end
      end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequences the direct-mapped data cache array and the single-ported data memory bus
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int MSHR_N = 4,
  parameter int ID_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_req_valid,
  input  logic [63:0]       ld_req_addr,
  input  logic [ID_W-1:0]   ld_req_id,
  output logic              ld_req_ready,
  input  logic              st_req_valid,
  input  logic [63:0]       st_req_addr,
  input  logic [63:0]       st_req_data,
  output logic              st_req_ready,
  output logic              ld_resp_valid,
  output logic [ID_W-1:0]   ld_resp_id,
  output logic [63:0]       ld_resp_data,
  output logic [IDX_W-1:0]  c_rd_idx,
  output logic [TAG_W-1:0]  c_rd_tag,
  input  logic [63:0]       c_rd_data,
  input  logic              c_rd_hit,
  output logic              c_wr0_en,
  output logic [IDX_W-1:0]  c_wr0_idx,
  output logic [TAG_W-1:0]  c_wr0_tag,
  output logic [63:0]       c_wr0_data,
  output logic              c_wr1_en,
  output logic [IDX_W-1:0]  c_wr1_idx,
  output logic [TAG_W-1:0]  c_wr1_tag,
  output logic [63:0]       c_wr1_data,
  output logic [1:0]        mem_cmd,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [MTAG_W-1:0] mem_response,
  input  logic [MTAG_W-1:0] mem_tag,
  input  logic [63:0]       mem_rdata,
  input  logic              halt_req,
  output logic              halt_done
);
  state_t state;
  logic fill, fill_nofill, full, empty, dup, run, st_go, ld_hit, ld_try, ld_alloc;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [ID_W-1:0] fill_id;
  dcache_mshr #(.N(MSHR_N), .ID_W(ID_W)) mshr (
    .clock(clock), .reset(reset),
    .alloc(ld_alloc), .alloc_mtag(mem_response), .alloc_idx(c_rd_idx), .alloc_tag(c_rd_tag), .alloc_id(ld_req_id),
    .fill_mtag(mem_tag), .fill_hit(fill), .fill_nofill(fill_nofill), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_id(fill_id),
    .mark(st_req_ready), .mark_idx(c_wr1_idx),
    .probe_mtag(mem_response), .probe_dup(dup),
    .full(full), .empty(empty)
  );
  // a fill cycle owns the response register, so loads wait; stores own the bus over misses
  always_comb begin
    run = state == RUN && !reset;
    st_go = run && st_req_valid;
    ld_hit = run && !fill && ld_req_valid && c_rd_hit;
    ld_try = run && !fill && ld_req_valid && !c_rd_hit && !full && !st_go;
    ld_alloc = ld_try && mem_response != '0 && !dup;
    ld_req_ready = ld_hit || ld_alloc;
    st_req_ready = st_go && mem_response != '0;
    c_rd_idx = addr_idx(ld_req_addr);
    c_rd_tag = addr_tag(ld_req_addr);
    c_wr0_en = fill && !fill_nofill && !reset;
    c_wr0_idx = fill_idx;
    c_wr0_tag = fill_tag;
    c_wr0_data = mem_rdata;
    c_wr1_en = st_req_ready;
    c_wr1_idx = addr_idx(st_req_addr);
    c_wr1_tag = addr_tag(st_req_addr);
    c_wr1_data = st_req_data;
    mem_cmd = st_go ? CMD_STORE : ld_try ? CMD_LOAD : CMD_NONE;
    mem_addr = (st_go ? st_req_addr : ld_req_addr) & ~64'h7;
    mem_wdata = st_req_data;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      halt_done <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_id <= '0;
      ld_resp_data <= '0;
    end else begin
      ld_resp_valid <= fill || ld_hit;
      ld_resp_id <= fill ? fill_id : ld_req_id;
      ld_resp_data <= fill ? mem_rdata : c_rd_data;
      state <= state == RUN && halt_req ? DRAIN : state == DRAIN && empty ? HALTED : state;
      halt_done <= halt_done || (state == DRAIN && empty);
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a behavioural cache array model
module tb_dcache_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic ld_req_valid = 1'b0, st_req_valid = 1'b0, halt_req = 1'b0;
  logic [63:0] ld_req_addr = '0, st_req_addr = '0, st_req_data = '0, mem_rdata = '0;
  logic [3:0] ld_req_id = '0, mem_response = '0, mem_tag = '0;
  logic ld_req_ready, st_req_ready, ld_resp_valid, c_rd_hit, c_wr0_en, c_wr1_en, halt_done;
  logic [3:0] ld_resp_id;
  logic [63:0] ld_resp_data, c_rd_data, c_wr0_data, c_wr1_data, mem_addr, mem_wdata;
  logic [6:0] c_rd_idx, c_wr0_idx, c_wr1_idx;
  logic [21:0] c_rd_tag, c_wr0_tag, c_wr1_tag;
  logic [1:0] mem_cmd;
  int checks = 0, failures = 0;
  typedef struct packed {logic [3:0] id; logic [63:0] data;} resp_t;
  resp_t exp_q[$];
  logic arr_v [128];
  logic [21:0] arr_t [128];
  logic [63:0] arr_d [128];

  always #5 clock = ~clock;

  dcache_ctrl #(.MSHR_N(4), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_id(ld_req_id), .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_req_ready(st_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_id(ld_resp_id), .ld_resp_data(ld_resp_data),
    .c_rd_idx(c_rd_idx), .c_rd_tag(c_rd_tag), .c_rd_data(c_rd_data), .c_rd_hit(c_rd_hit),
    .c_wr0_en(c_wr0_en), .c_wr0_idx(c_wr0_idx), .c_wr0_tag(c_wr0_tag), .c_wr0_data(c_wr0_data),
    .c_wr1_en(c_wr1_en), .c_wr1_idx(c_wr1_idx), .c_wr1_tag(c_wr1_tag), .c_wr1_data(c_wr1_data),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_rdata(mem_rdata),
    .halt_req(halt_req), .halt_done(halt_done)
  );

  // cache array: fill port first, store port second so it wins on the same index
  assign c_rd_hit = arr_v[c_rd_idx] && arr_t[c_rd_idx] == c_rd_tag;
  assign c_rd_data = arr_d[c_rd_idx];
  always @(posedge clock)
    if (reset) for (int i = 0; i < 128; i++) arr_v[i] <= 1'b0;
    else begin
      if (c_wr0_en) begin arr_v[c_wr0_idx] <= 1'b1; arr_t[c_wr0_idx] <= c_wr0_tag; arr_d[c_wr0_idx] <= c_wr0_data; end
      if (c_wr1_en) begin arr_v[c_wr1_idx] <= 1'b1; arr_t[c_wr1_idx] <= c_wr1_tag; arr_d[c_wr1_idx] <= c_wr1_data; end
    end

  always @(negedge clock)
    if (!reset && ld_resp_valid) begin
      resp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected got id=%0d data=%h exp none", ld_resp_id, ld_resp_data);
      end else begin
        e = exp_q.pop_front();
        if ({ld_resp_id, ld_resp_data} !== e) begin
          failures++;
          $display("FAIL resp got id=%0d data=%h exp id=%0d data=%h", ld_resp_id, ld_resp_data, e.id, e.data);
        end
      end
    end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    ld_req_valid = 1'b0; st_req_valid = 1'b0; mem_response = '0; mem_tag = '0; halt_req = 1'b0;
  endtask

  task automatic load(input logic [63:0] a, input logic [3:0] id, input logic [3:0] resp);
    ld_req_valid = 1'b1; ld_req_addr = a; ld_req_id = id; mem_response = resp;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ld_req_valid = 1'b1; st_req_valid = 1'b1; st_req_addr = 64'h8; mem_response = 4'd1; mem_tag = 4'd1;
    tick; tick;
    checks++; if (mem_cmd !== 2'd0) begin failures++; $display("FAIL rst_cmd got=%0d exp=0", mem_cmd); end
    checks++; if ({c_wr0_en, c_wr1_en} !== 2'b00) begin failures++; $display("FAIL rst_wr got=%b exp=00", {c_wr0_en, c_wr1_en}); end
    checks++; if ({ld_req_ready, st_req_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {ld_req_ready, st_req_ready}); end
    checks++; if ({ld_resp_valid, ld_resp_id, ld_resp_data} !== 69'd0) begin failures++; $display("FAIL rst_resp got v=%b id=%0d d=%h exp 0", ld_resp_valid, ld_resp_id, ld_resp_data); end
    idle; reset = 1'b0;
    tick;
    checks++; if ({ld_resp_valid, halt_done} !== 2'b00) begin failures++; $display("FAIL rst_after got=%b exp=00", {ld_resp_valid, halt_done}); end
  endtask

  task automatic test_miss_fill;
    load(64'h1008, 4'd3, 4'd5);
    checks++; if (mem_cmd !== 2'd1) begin failures++; $display("FAIL miss_cmd got=%0d exp=1", mem_cmd); end
    checks++; if (mem_addr !== 64'h1008) begin failures++; $display("FAIL miss_addr got=%h exp=1008", mem_addr); end
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL miss_ready got=%b exp=1", ld_req_ready); end
    tick; idle; tick;
    mem_tag = 4'd5; mem_rdata = 64'hAB; #1;
    checks++; if ({c_wr0_en, c_wr0_idx, c_wr0_tag, c_wr0_data} !== {1'b1, 7'd1, 22'h4, 64'hAB}) begin
      failures++; $display("FAIL fill_wr got en=%b idx=%0d tag=%h d=%h exp 1/1/4/ab", c_wr0_en, c_wr0_idx, c_wr0_tag, c_wr0_data);
    end
    exp_q.push_back({4'd3, 64'hAB});
    tick; idle;
    load(64'h1008, 4'd9, 4'd0);
    checks++; if ({ld_req_ready, mem_cmd} !== 3'b100) begin failures++; $display("FAIL hit got rdy=%b cmd=%0d exp 1/0", ld_req_ready, mem_cmd); end
    exp_q.push_back({4'd9, 64'hAB});
    tick; idle; tick;
  endtask

  task automatic test_mshr_full;
    int ord[4] = '{3, 1, 4, 2};
    for (int i = 0; i < 4; i++) begin
      load(64'h4000 + 64'(8 * i), 4'(i), 4'(i + 1));
      checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL full_alloc%0d got=%b exp=1", i, ld_req_ready); end
      tick;
    end
    load(64'h4020, 4'd5, 4'd6);
    checks++; if ({ld_req_ready, mem_cmd} !== 3'b000) begin failures++; $display("FAIL full_stall got rdy=%b cmd=%0d exp 0/0", ld_req_ready, mem_cmd); end
    tick;
    load(64'h1008, 4'd6, 4'd0);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL full_hit got=%b exp=1", ld_req_ready); end
    exp_q.push_back({4'd6, 64'hAB});
    tick; idle;
    for (int k = 0; k < 4; k++) begin
      mem_tag = 4'(ord[k]); mem_rdata = 64'hF00 + 64'(ord[k]); #1;
      exp_q.push_back({4'(ord[k] - 1), 64'hF00 + 64'(ord[k])});
      checks++; if ({c_wr0_en, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL full_fill%0d got=%b exp=10", k, {c_wr0_en, ld_req_ready}); end
      tick;
    end
    idle;
    load(64'h4020, 4'd5, 4'd6);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL full_freed got=%b exp=1", ld_req_ready); end
    tick; idle;
    mem_tag = 4'd6; mem_rdata = 64'h66;
    exp_q.push_back({4'd5, 64'h66});
    tick; idle; tick;
  endtask

  task automatic test_store_during_miss;
    load(64'h2000, 4'd7, 4'd7);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL sdm_miss got=%b exp=1", ld_req_ready); end
    tick; idle;
    st_req_valid = 1'b1; st_req_addr = 64'h2000; st_req_data = 64'h55; mem_response = 4'd1; #1;
    checks++; if ({mem_cmd, st_req_ready, c_wr1_en} !== 4'b1011) begin failures++; $display("FAIL sdm_store got cmd=%0d rdy=%b wr=%b exp 2/1/1", mem_cmd, st_req_ready, c_wr1_en); end
    checks++; if ({c_wr1_idx, c_wr1_tag, c_wr1_data, mem_wdata} !== {7'd0, 22'h8, 64'h55, 64'h55}) begin
      failures++; $display("FAIL sdm_wr1 got idx=%0d tag=%h d=%h wd=%h exp 0/8/55/55", c_wr1_idx, c_wr1_tag, c_wr1_data, mem_wdata);
    end
    tick; idle;
    mem_tag = 4'd7; mem_rdata = 64'h11; #1;
    checks++; if (c_wr0_en !== 1'b0) begin failures++; $display("FAIL sdm_nofill got=%b exp=0", c_wr0_en); end
    exp_q.push_back({4'd7, 64'h11});
    tick; idle;
    checks++; if ({arr_t[0], arr_d[0]} !== {22'h8, 64'h55}) begin failures++; $display("FAIL sdm_array got tag=%h d=%h exp 8/55", arr_t[0], arr_d[0]); end
    load(64'h2000, 4'd8, 4'd0);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL sdm_hit got=%b exp=1", ld_req_ready); end
    exp_q.push_back({4'd8, 64'h55});
    tick; idle; tick;
  endtask

  task automatic test_bus_arb;
    st_req_valid = 1'b1; st_req_addr = 64'h5008; st_req_data = 64'h77;
    load(64'h3005, 4'd1, 4'd2);
    checks++; if ({mem_cmd, ld_req_ready, st_req_ready} !== 4'b1001) begin failures++; $display("FAIL arb got cmd=%0d lrdy=%b srdy=%b exp 2/0/1", mem_cmd, ld_req_ready, st_req_ready); end
    checks++; if (mem_addr !== 64'h5008) begin failures++; $display("FAIL arb_addr got=%h exp=5008", mem_addr); end
    tick;
    ld_req_valid = 1'b0; st_req_addr = 64'h5010; mem_response = 4'd0; #1;
    checks++; if ({mem_cmd, st_req_ready, c_wr1_en} !== 4'b1000) begin failures++; $display("FAIL st_reject got cmd=%0d rdy=%b wr=%b exp 2/0/0", mem_cmd, st_req_ready, c_wr1_en); end
    tick;
    mem_response = 4'd3; #1;
    checks++; if (st_req_ready !== 1'b1) begin failures++; $display("FAIL st_retry got=%b exp=1", st_req_ready); end
    tick; idle;
    load(64'h3005, 4'd1, 4'd9);
    checks++; if ({ld_req_ready, mem_addr} !== {1'b1, 64'h3000}) begin failures++; $display("FAIL ld_align got rdy=%b addr=%h exp 1/3000", ld_req_ready, mem_addr); end
    tick;
    load(64'h3808, 4'd2, 4'd9);
    checks++; if ({ld_req_ready, mem_cmd} !== 3'b001) begin failures++; $display("FAIL dup_reject got rdy=%b cmd=%0d exp 0/1", ld_req_ready, mem_cmd); end
    tick; idle;
    mem_tag = 4'hE; mem_rdata = 64'hEE; #1;
    checks++; if (c_wr0_en !== 1'b0) begin failures++; $display("FAIL tag_unmatched got=%b exp=0", c_wr0_en); end
    tick;
    mem_tag = 4'd9; mem_rdata = 64'h99; #1;
    exp_q.push_back({4'd1, 64'h99});
    checks++; if (c_wr0_en !== 1'b1) begin failures++; $display("FAIL arb_fill got=%b exp=1", c_wr0_en); end
    tick; idle; tick;
  endtask

  task automatic test_halt;
    int n = 0;
    load(64'h6000, 4'd4, 4'd1);
    tick;
    load(64'h6008, 4'd5, 4'd2);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL halt_pre got=%b exp=1", ld_req_ready); end
    tick; idle;
    halt_req = 1'b1;
    tick; halt_req = 1'b0;
    st_req_valid = 1'b1; st_req_addr = 64'h6018;
    load(64'h6010, 4'd6, 4'd3);
    checks++; if ({ld_req_ready, st_req_ready, mem_cmd, halt_done} !== 5'b0) begin
      failures++; $display("FAIL drain_block got l=%b s=%b cmd=%0d hd=%b exp 0", ld_req_ready, st_req_ready, mem_cmd, halt_done);
    end
    tick; idle;
    mem_tag = 4'd1; mem_rdata = 64'hA1; #1;
    exp_q.push_back({4'd4, 64'hA1});
    checks++; if (c_wr0_en !== 1'b1) begin failures++; $display("FAIL drain_fill got=%b exp=1", c_wr0_en); end
    tick; idle;
    checks++; if (halt_done !== 1'b0) begin failures++; $display("FAIL drain_early got=%b exp=0", halt_done); end
    mem_tag = 4'd2; mem_rdata = 64'hA2;
    exp_q.push_back({4'd5, 64'hA2});
    tick; idle;
    while (halt_done !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (halt_done !== 1'b1) begin failures++; $display("FAIL halt_done_set got=%b exp=1 within 10 cycles", halt_done); end
    halt_req = 1'b1;
    tick; halt_req = 1'b0;
    tick; tick;
    load(64'h6000, 4'd7, 4'd4);
    checks++; if ({halt_done, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL halt_sticky got hd=%b rdy=%b exp 1/0", halt_done, ld_req_ready); end
    tick; idle;
  endtask

  task automatic test_reset_drain;
    reset = 1'b1; tick; reset = 1'b0; tick;
    load(64'h7000, 4'd10, 4'd3);
    checks++; if (ld_req_ready !== 1'b1) begin failures++; $display("FAIL rd_miss got=%b exp=1", ld_req_ready); end
    tick; idle;
    halt_req = 1'b1; tick; halt_req = 1'b0; tick;
    checks++; if (halt_done !== 1'b0) begin failures++; $display("FAIL rd_draining got=%b exp=0", halt_done); end
    reset = 1'b1; tick; reset = 1'b0;
    st_req_valid = 1'b1; st_req_addr = 64'h7000; st_req_data = 64'h42; mem_response = 4'd1; #1;
    checks++; if ({st_req_ready, halt_done} !== 2'b10) begin failures++; $display("FAIL rd_run got rdy=%b hd=%b exp 1/0", st_req_ready, halt_done); end
    tick; idle;
    mem_tag = 4'd3; mem_rdata = 64'hBAD; #1;
    checks++; if (c_wr0_en !== 1'b0) begin failures++; $display("FAIL rd_stale got=%b exp=0", c_wr0_en); end
    tick; idle; tick;
    checks++; if (ld_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_noresp got=%b exp=0", ld_resp_valid); end
    tick;
  endtask

  initial begin
    test_reset;
    test_miss_fill;
    test_mshr_full;
    test_store_during_miss;
    test_bus_arb;
    test_halt;
    test_reset_drain;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL resp_missing got=%0d pending exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
